tb_clock_sched: RTL

//  Scheduler for a bank of NUM_CLK testbench clock generators. Holds shadow timing configs
//  (IEEE-754 bit patterns) and latches them into active registers at arm time. Drives each

---
 rtl/tb_clock_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tb_clock_sched.sv
// tb_clock_sched
//   Scheduler for a bank of NUM_CLK testbench clock generators. Shadow timing
//   configs (IEEE-754 bit patterns) are written at any time and copied into the
//   active registers when the scheduler arms. One command port starts, stops and
//   restarts every enabled generator through its tb_status pair. A run can end
//   on its own after run_cycles CLK cycles.
// Ports
//   CLK, RST            scheduler clock, async active-high reset
//   cfg_we/sel/field    shadow config write (out-of-range sel or field dropped)
//   cfg_wdata           64-bit $realtobits pattern
//   en_mask             generators requested to run (sampled at arm)
//   cmd_valid/op/ready  command handshake: 0 NOP, 1 START, 2 STOP, 3 RESTART
//   run_cycles          run length in CLK cycles, 0 = until STOP
//   tb_status           pair k: [2k] run level, [2k+1] stop pulse
//   <field>_bits        active config per generator, slice k = 64*k +: 64
//   act_mask            generators running in this run
//   invalid_mask        requested but rejected at last arm
//   cycle_count         cycles spent in current/last run
//   done, start_err     one-cycle status pulses
module tb_clock_sched #(
  parameter int NUM_CLK = 4,
  parameter int CNT_W   = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_sel,
  input  logic [3:0]            cfg_field,
  input  logic [63:0]           cfg_wdata,
  input  logic [NUM_CLK-1:0]    en_mask,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  output logic                  cmd_ready,
  input  logic [CNT_W-1:0]      run_cycles,
  output logic [2*NUM_CLK-1:0]  tb_status,
  output logic [64*NUM_CLK-1:0] offset_bits,
  output logic [64*NUM_CLK-1:0] period_bits,
  output logic [64*NUM_CLK-1:0] duty_bits,
  output logic [64*NUM_CLK-1:0] minLH_bits,
  output logic [64*NUM_CLK-1:0] maxLH_bits,
  output logic [64*NUM_CLK-1:0] minHL_bits,
  output logic [64*NUM_CLK-1:0] maxHL_bits,
  output logic [64*NUM_CLK-1:0] jRise_bits,
  output logic [64*NUM_CLK-1:0] jFall_bits,
  output logic [NUM_CLK-1:0]    act_mask,
  output logic [NUM_CLK-1:0]    invalid_mask,
  output logic [CNT_W-1:0]      cycle_count,
  output logic                  done,
  output logic                  start_err
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_t;

  localparam logic [1:0] OP_START   = 2'd1;
  localparam logic [1:0] OP_STOP    = 2'd2;
  localparam logic [1:0] OP_RESTART = 2'd3;

  // Field index: 0 offset,1 period,2 duty,3 minLH,4 maxLH,5 minHL,6 maxHL,7 jRise,8 jFall
  logic [63:0] shadow [NUM_CLK][9];
  logic [63:0] active [NUM_CLK][9];

  state_t             state;
  logic [NUM_CLK-1:0] valid;
  logic               accept, hit, stop_go, arm_go;

  function automatic logic [2*NUM_CLK-1:0] spread(input logic [NUM_CLK-1:0] m,
                                                  input int unsigned off);
    logic [2*NUM_CLK-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NUM_CLK; k++) r[2*k+off] = m[k];
    return r;
  endfunction

  // Period and duty must both be strictly positive (sign clear, magnitude nonzero).
  always_comb begin
    valid = '0;
    for (int unsigned k = 0; k < NUM_CLK; k++)
      valid[k] = !shadow[k][1][63] && (shadow[k][1][62:0] != '0) &&
                 !shadow[k][2][63] && (shadow[k][2][62:0] != '0);
  end

  assign accept  = cmd_valid && cmd_ready;
  assign hit     = (run_cycles != '0) && (cycle_count == run_cycles);
  // A STOP command coinciding with the run-length hit is a single STOP entry.
  assign stop_go = (state == RUN) && ((accept && cmd_op == OP_STOP) || hit);
  assign arm_go  = accept && (((state == IDLE) && (cmd_op == OP_START)) ||
                              ((state == RUN) && !stop_go && (cmd_op == OP_RESTART)));

  always_comb begin
    offset_bits = '0; period_bits = '0; duty_bits  = '0;
    minLH_bits  = '0; maxLH_bits  = '0; minHL_bits = '0;
    maxHL_bits  = '0; jRise_bits  = '0; jFall_bits = '0;
    for (int unsigned k = 0; k < NUM_CLK; k++) begin
      offset_bits[64*k +: 64] = active[k][0];
      period_bits[64*k +: 64] = active[k][1];
      duty_bits[64*k +: 64]   = active[k][2];
      minLH_bits[64*k +: 64]  = active[k][3];
      maxLH_bits[64*k +: 64]  = active[k][4];
      minHL_bits[64*k +: 64]  = active[k][5];
      maxHL_bits[64*k +: 64]  = active[k][6];
      jRise_bits[64*k +: 64]  = active[k][7];
      jFall_bits[64*k +: 64]  = active[k][8];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      tb_status    <= '0;
      act_mask     <= '0;
      invalid_mask <= '0;
      cycle_count  <= '0;
      done         <= 1'b0;
      start_err    <= 1'b0;
      for (int unsigned k = 0; k < NUM_CLK; k++)
        for (int unsigned f = 0; f < 9; f++) begin
          shadow[k][f] <= '0;
          active[k][f] <= '0;
        end
    end else begin
      done      <= 1'b0;
      start_err <= 1'b0;

      for (int unsigned k = 0; k < NUM_CLK; k++)
        for (int unsigned f = 0; f < 9; f++)
          if (cfg_we && cfg_sel == 4'(k) && cfg_field == 4'(f))
            shadow[k][f] <= cfg_wdata;

      // Arm actions are taken on the accepting edge, so the ARM cycle already
      // shows the latched masks and a zero count; run bits rise one edge later.
      if (arm_go) begin
        state        <= ARM;
        cmd_ready    <= 1'b0;
        tb_status    <= '0;
        act_mask     <= en_mask & valid;
        invalid_mask <= en_mask & ~valid;
        cycle_count  <= '0;
        for (int unsigned k = 0; k < NUM_CLK; k++)
          for (int unsigned f = 0; f < 9; f++)
            active[k][f] <= shadow[k][f];
      end else begin
        case (state)
          ARM: begin
            cmd_ready <= 1'b1;
            if (act_mask == '0) begin
              state     <= IDLE;
              start_err <= 1'b1;
            end else begin
              state       <= RUN;
              tb_status   <= spread(act_mask, 0);
              cycle_count <= CNT_W'(1);
            end
          end
          RUN: begin
            if (stop_go) begin
              state     <= STOP;
              cmd_ready <= 1'b0;
              done      <= 1'b1;
              tb_status <= spread(act_mask, 1);
            end else if (cycle_count != '1) begin
              cycle_count <= cycle_count + 1'b1;
            end
          end
          STOP: begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            tb_status <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
